adc_fifo_packer: RTL
====================

ADC_FIFO_PACKER -- requirements
Module: adc_fifo_packer

Interface
REQ-001 Parameter RD_LATENCY, default 1; cycles from FIFO_RE high to FIFO_Q valid (legal 1..3).
REQ-002 Parameter TIMEOUT, default 255; empty-FIFO cycles before a half word is flushed (legal 1..65535).
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 ENABLE  input  1  permits new FIFO reads when high.
REQ-006 FIFO_EMPTY  input  1  EMPTY flag of the upstream 1024x16 ADC sample FIFO.
REQ-007 FIFO_FULL  input  1  FULL flag of the same FIFO.
REQ-008 FIFO_Q  input  16  FIFO read data.
REQ-009 FIFO_RE  output  1  active-high single-cycle read strobe to the FIFO.
REQ-010 M_DATA  output  32  packed word; older sample in [15:0], newer sample in [31:16].
REQ-011 M_VALID  output  1  M_DATA/M_HALF valid.
REQ-012 M_READY  input  1  downstream accepts the word.
REQ-013 M_HALF  output  1  word carries only [15:0]; [31:16] = 0.
REQ-014 OVF  output  1  sticky FIFO-full flag.
REQ-015 CLR_OVF  input  1  synchronous clear of OVF.
REQ-016 WORD_CNT  output  16  count of words transferred.

Function
REQ-017 FSM states SHALL be: IDLE, WAIT_LO, HAVE_LO, WAIT_HI, OUT.
REQ-018 IDLE->WAIT_LO when ENABLE=1 and FIFO_EMPTY=0; FIFO_RE=1 for exactly that cycle.
REQ-019 WAIT_LO SHALL count RD_LATENCY cycles after the strobe, latch FIFO_Q into M_DATA[15:0] on the cycle it is valid, then enter HAVE_LO.
REQ-020 HAVE_LO->WAIT_HI when ENABLE=1 and FIFO_EMPTY=0, pulsing FIFO_RE for one cycle.
REQ-021 WAIT_HI SHALL latch FIFO_Q into M_DATA[31:16] after RD_LATENCY cycles, then enter OUT with M_VALID=1, M_HALF=0.
REQ-022 At most one read SHALL be in flight; FIFO_RE SHALL never assert in WAIT_LO, WAIT_HI or OUT.
REQ-023 In OUT, M_DATA, M_HALF and M_VALID SHALL hold stable until M_READY=1; the transfer cycle returns the FSM to IDLE and clears M_VALID on the next edge.
REQ-024 A new read SHALL NOT be issued in the same cycle as a transfer; first FIFO_RE after a transfer occurs no earlier than the cycle following it.
REQ-025 Timeout counter SHALL count consecutive HAVE_LO cycles without a read issued; reset to 0 on entry to HAVE_LO and on every FIFO_RE.
REQ-026 When the counter reaches TIMEOUT, the FSM SHALL enter OUT with M_HALF=1, M_DATA[31:16]=0.
REQ-027 Timeout SHALL expire regardless of ENABLE; ENABLE=0 blocks only new reads, never an in-flight read or a pending word.
REQ-028 OVF SHALL set on any cycle with FIFO_FULL=1 and clear on CLR_OVF=1; simultaneous set and clear leaves OVF=1.
REQ-029 WORD_CNT SHALL increment by 1 per transfer (M_VALID & M_READY), wrapping 0xFFFF->0x0000; half words count.
REQ-030 FIFO_RE SHALL be a registered output.

Reset
REQ-031 RESET=0 SHALL asynchronously force: state IDLE, FIFO_RE=0, M_VALID=0, M_HALF=0, M_DATA=0, OVF=0, WORD_CNT=0, timeout and latency counters 0.
REQ-032 Reset mid-operation SHALL discard any held sample and in-flight read; an in-flight FIFO_Q arriving after release SHALL be ignored.
REQ-033 The first FIFO_RE after RESET deassertion SHALL occur no earlier than the second rising edge after release.

Verification
REQ-034 FIFO preloaded 0x0001,0x0002, ENABLE=1, M_READY=1, RD_LATENCY=1 -> exactly two FIFO_RE pulses, M_DATA=0x00020001, M_HALF=0, WORD_CNT=1.
REQ-035 Same stimulus, M_READY=0 for 10 cycles then 1 -> M_VALID high 10+ cycles with M_DATA stable, no FIFO_RE during stall, single transfer.
REQ-036 One sample 0xABCD then FIFO empty, TIMEOUT=4 -> M_VALID after 4 HAVE_LO cycles, M_DATA=0x0000ABCD, M_HALF=1.
REQ-037 FIFO_FULL pulsed 1 cycle, later CLR_OVF coincident with FIFO_FULL -> OVF=1 after first pulse, stays 1 after the coincident cycle, clears on a lone CLR_OVF.
REQ-038 RESET asserted during WAIT_HI -> all outputs at reset values immediately; after release with FIFO holding 0x0003,0x0004 -> next word 0x00040003.
REQ-039 65536 words transferred -> WORD_CNT wraps to 0x0000; ENABLE=0 at start -> no FIFO_RE issued while FIFO_EMPTY=0.

Source files
------------

// File: rtl/adc_fifo_packer.sv
// Packs pairs of 16-bit ADC samples from an upstream FIFO into 32-bit words,
// flushing a lone sample as a half word after TIMEOUT idle cycles.
module adc_fifo_packer #(
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_fifo_empty,
    input  logic        i_fifo_full,
    input  logic [15:0] i_fifo_q,
    output logic        o_fifo_re,
    output logic [31:0] o_m_data,
    output logic        o_m_valid,
    input  logic        i_m_ready,
    output logic        o_m_half,
    output logic        o_ovf,
    input  logic        i_clr_ovf,
    output logic [15:0] o_word_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT_LO, HAVE_LO, WAIT_HI, OUT} state_t;

    localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_fifo_re;
    logic [31:0] r_m_data;
    logic        r_m_valid;
    logic        r_m_half;
    logic        r_ovf;
    logic [15:0] r_word_cnt;
    logic [1:0]  r_lat_cnt;
    logic [15:0] r_to_cnt;
    logic        r_armed;

    logic        w_can_read;
    logic        w_issue_re;
    logic        w_latch_lo;
    logic        w_latch_hi;
    logic        w_timeout;
    logic        w_xfer;

    // r_armed holds off the first read until one full cycle after reset release.
    assign w_can_read = i_enable & ~i_fifo_empty & r_armed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue_re   = 1'b0;
        w_latch_lo   = 1'b0;
        w_latch_hi   = 1'b0;
        w_timeout    = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_read) begin
                    w_next_state = WAIT_LO;
                    w_issue_re   = 1'b1;
                end
            end
            WAIT_LO: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_next_state = HAVE_LO;
                    w_latch_lo   = 1'b1;
                end
            end
            HAVE_LO: begin
                // A read wins over the timeout when both are possible.
                if (w_can_read) begin
                    w_next_state = WAIT_HI;
                    w_issue_re   = 1'b1;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next_state = OUT;
                    w_timeout    = 1'b1;
                end
            end
            WAIT_HI: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_next_state = OUT;
                    w_latch_hi   = 1'b1;
                end
            end
            OUT: begin
                if (i_m_ready) begin
                    w_next_state = IDLE;
                    w_xfer       = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo_re  <= 1'b0;
            r_m_data   <= 32'h0;
            r_m_valid  <= 1'b0;
            r_m_half   <= 1'b0;
            r_word_cnt <= 16'h0;
            r_lat_cnt  <= 2'd0;
            r_to_cnt   <= 16'h0;
            r_armed    <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_fifo_re <= w_issue_re;

            if (w_issue_re) begin
                r_lat_cnt <= 2'd0;
            end else if (r_state == WAIT_LO || r_state == WAIT_HI) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end

            if (w_latch_lo || w_issue_re) begin
                r_to_cnt <= 16'h0;
            end else if (r_state == HAVE_LO) begin
                r_to_cnt <= r_to_cnt + 16'h1;
            end

            // Clearing the upper half here makes a timed-out half word carry zeros.
            if (w_latch_lo) begin
                r_m_data <= {16'h0, i_fifo_q};
            end else if (w_latch_hi) begin
                r_m_data[31:16] <= i_fifo_q;
            end

            if (w_latch_hi || w_timeout) begin
                r_m_valid <= 1'b1;
            end else if (w_xfer) begin
                r_m_valid <= 1'b0;
            end

            if (w_timeout) begin
                r_m_half <= 1'b1;
            end else if (w_latch_hi || w_xfer) begin
                r_m_half <= 1'b0;
            end

            if (w_xfer) begin
                r_word_cnt <= r_word_cnt + 16'h1;
            end
        end
    end

    // Set has priority over clear so a coincident full flag is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (i_fifo_full) begin
            r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_fifo_re  = r_fifo_re;
    assign o_m_data   = r_m_data;
    assign o_m_valid  = r_m_valid;
    assign o_m_half   = r_m_half;
    assign o_ovf      = r_ovf;
    assign o_word_cnt = r_word_cnt;

endmodule
